// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle control FSM and the datapath/memory.
// The FSM connects through the master modport; the datapath (or a bench) through slave.
interface multicycle_control_fsm_if;
    // Instruction register fields and datapath status
    logic [5:0] Opcode_i;
    logic [5:0] Funct_i;
    logic       Zero_i;
    logic       Mem_Ready_i;

    // Datapath enables and mux selects
    logic       PC_Write_o;
    logic       IorD_o;
    logic       Mem_Read_o;
    logic       Mem_Write_o;
    logic       IR_Write_o;
    logic       Reg_Write_o;
    logic [1:0] Reg_Dst_Sel_o;
    logic [1:0] Mem_to_Reg_Sel_o;
    logic       ALU_Src_A_o;
    logic [1:0] ALU_Src_B_o;
    logic [1:0] ALU_Op_o;
    logic [1:0] PC_Source_o;
    logic       Illegal_Op_o;

    modport master (
        input  Opcode_i, Funct_i, Zero_i, Mem_Ready_i,
        output PC_Write_o, IorD_o, Mem_Read_o, Mem_Write_o, IR_Write_o, Reg_Write_o,
               Reg_Dst_Sel_o, Mem_to_Reg_Sel_o, ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o,
               PC_Source_o, Illegal_Op_o
    );

    modport slave (
        output Opcode_i, Funct_i, Zero_i, Mem_Ready_i,
        input  PC_Write_o, IorD_o, Mem_Read_o, Mem_Write_o, IR_Write_o, Reg_Write_o,
               Reg_Dst_Sel_o, Mem_to_Reg_Sel_o, ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o,
               PC_Source_o, Illegal_Op_o
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle MIPS core: sequences fetch, decode, execute,
// memory and write-back, and drives every datapath enable and mux select.
// Outputs are a Moore decode of the state, except FETCH PC/IR write (gated by the
// memory handshake) and BRANCH PC write (gated by the ALU zero flag). All outputs
// are held at 0 while reset is low.
// Optional build macro PERF_COUNTERS_EN adds cycle and retired-instruction counters.
module multicycle_control_fsm
`ifdef PERF_COUNTERS_EN
#(
    parameter int unsigned NBits = 32
)
`endif
(
    input  logic                    clk,
    input  logic                    reset,
    multicycle_control_fsm_if.master ctrl
`ifdef PERF_COUNTERS_EN
    ,
    output logic [NBits-1:0]        Cycle_Count_o,
    output logic [NBits-1:0]        Retired_Count_o
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    // Mux select encodings
    localparam logic [1:0] DST_RT     = 2'd0;
    localparam logic [1:0] DST_RD     = 2'd1;
    localparam logic [1:0] DST_RA     = 2'd2;
    localparam logic [1:0] WD_ALU     = 2'd0;
    localparam logic [1:0] WD_MEM     = 2'd1;
    localparam logic [1:0] WD_PC4     = 2'd2;
    localparam logic [1:0] SRCB_B     = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_IMMSH = 2'd3;
    localparam logic [1:0] ALU_ADD    = 2'd0;
    localparam logic [1:0] ALU_SUB    = 2'd1;
    localparam logic [1:0] ALU_FUNCT  = 2'd2;
    localparam logic [1:0] ALU_IOP    = 2'd3;
    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;
    localparam logic [1:0] PCS_REGA   = 2'd3;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_R_WB      = 4'd7,
        S_EXEC_I    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_JAL       = 4'd12,
        S_JR        = 4'd13
    } state_t;

    state_t state;
    state_t next_state;

    // State register; reset restarts at instruction fetch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode; everything stays 0 while reset is asserted
    always_comb begin
        next_state             = state;
        ctrl.PC_Write_o        = 1'b0;
        ctrl.IorD_o            = 1'b0;
        ctrl.Mem_Read_o        = 1'b0;
        ctrl.Mem_Write_o       = 1'b0;
        ctrl.IR_Write_o        = 1'b0;
        ctrl.Reg_Write_o       = 1'b0;
        ctrl.Reg_Dst_Sel_o     = DST_RT;
        ctrl.Mem_to_Reg_Sel_o  = WD_ALU;
        ctrl.ALU_Src_A_o       = 1'b0;
        ctrl.ALU_Src_B_o       = SRCB_B;
        ctrl.ALU_Op_o          = ALU_ADD;
        ctrl.PC_Source_o       = PCS_ALU;
        ctrl.Illegal_Op_o      = 1'b0;

        if (reset) begin
            unique case (state)
                S_FETCH: begin
                    // PC+4 computed alongside the instruction read
                    ctrl.Mem_Read_o  = 1'b1;
                    ctrl.ALU_Src_B_o = SRCB_FOUR;
                    ctrl.PC_Write_o  = ctrl.Mem_Ready_i;
                    ctrl.IR_Write_o  = ctrl.Mem_Ready_i;
                    if (ctrl.Mem_Ready_i) begin
                        next_state = S_DECODE;
                    end
                end
                S_DECODE: begin
                    // Speculative branch target into ALUOut
                    ctrl.ALU_Src_B_o = SRCB_IMMSH;
                    case (ctrl.Opcode_i)
                        OP_RTYPE: next_state = (ctrl.Funct_i == FN_JR) ? S_JR : S_EXEC_R;
                        OP_LW,
                        OP_SW:    next_state = S_MEM_ADDR;
                        OP_BEQ,
                        OP_BNE:   next_state = S_BRANCH;
                        OP_ADDI,
                        OP_ANDI,
                        OP_ORI,
                        OP_LUI:   next_state = S_EXEC_I;
                        OP_J:     next_state = S_JUMP;
                        OP_JAL:   next_state = S_JAL;
                        default: begin
                            ctrl.Illegal_Op_o = 1'b1;
                            next_state        = S_FETCH;
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    ctrl.ALU_Src_A_o = 1'b1;
                    ctrl.ALU_Src_B_o = SRCB_IMM;
                    next_state = (ctrl.Opcode_i == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
                end
                S_MEM_READ: begin
                    ctrl.Mem_Read_o = 1'b1;
                    ctrl.IorD_o     = 1'b1;
                    if (ctrl.Mem_Ready_i) begin
                        next_state = S_MEM_WB;
                    end
                end
                S_MEM_WB: begin
                    ctrl.Reg_Write_o      = 1'b1;
                    ctrl.Reg_Dst_Sel_o    = DST_RT;
                    ctrl.Mem_to_Reg_Sel_o = WD_MEM;
                    next_state = S_FETCH;
                end
                S_MEM_WRITE: begin
                    ctrl.Mem_Write_o = 1'b1;
                    ctrl.IorD_o      = 1'b1;
                    if (ctrl.Mem_Ready_i) begin
                        next_state = S_FETCH;
                    end
                end
                S_EXEC_R: begin
                    ctrl.ALU_Src_A_o = 1'b1;
                    ctrl.ALU_Src_B_o = SRCB_B;
                    ctrl.ALU_Op_o    = ALU_FUNCT;
                    next_state = S_R_WB;
                end
                S_R_WB: begin
                    ctrl.Reg_Write_o      = 1'b1;
                    ctrl.Reg_Dst_Sel_o    = DST_RD;
                    ctrl.Mem_to_Reg_Sel_o = WD_ALU;
                    next_state = S_FETCH;
                end
                S_EXEC_I: begin
                    ctrl.ALU_Src_A_o = 1'b1;
                    ctrl.ALU_Src_B_o = SRCB_IMM;
                    ctrl.ALU_Op_o    = ALU_IOP;
                    next_state = S_I_WB;
                end
                S_I_WB: begin
                    ctrl.Reg_Write_o      = 1'b1;
                    ctrl.Reg_Dst_Sel_o    = DST_RT;
                    ctrl.Mem_to_Reg_Sel_o = WD_ALU;
                    next_state = S_FETCH;
                end
                S_BRANCH: begin
                    // Compare A and B; take the target held in ALUOut on condition
                    ctrl.ALU_Src_A_o = 1'b1;
                    ctrl.ALU_Src_B_o = SRCB_B;
                    ctrl.ALU_Op_o    = ALU_SUB;
                    ctrl.PC_Source_o = PCS_ALUOUT;
                    ctrl.PC_Write_o  = (ctrl.Opcode_i == OP_BEQ) ? ctrl.Zero_i : ~ctrl.Zero_i;
                    next_state = S_FETCH;
                end
                S_JUMP: begin
                    ctrl.PC_Source_o = PCS_JUMP;
                    ctrl.PC_Write_o  = 1'b1;
                    next_state = S_FETCH;
                end
                S_JAL: begin
                    // Link: PC+4 into $31 while loading the jump target
                    ctrl.PC_Source_o      = PCS_JUMP;
                    ctrl.PC_Write_o       = 1'b1;
                    ctrl.Reg_Write_o      = 1'b1;
                    ctrl.Reg_Dst_Sel_o    = DST_RA;
                    ctrl.Mem_to_Reg_Sel_o = WD_PC4;
                    next_state = S_FETCH;
                end
                S_JR: begin
                    ctrl.PC_Source_o = PCS_REGA;
                    ctrl.PC_Write_o  = 1'b1;
                    next_state = S_FETCH;
                end
                default: begin
                    next_state = S_FETCH;
                end
            endcase
        end
    end

`ifdef PERF_COUNTERS_EN
    // An instruction retires when it returns to FETCH; the illegal-opcode exit leaves from DECODE
    logic retire;
    assign retire = (next_state == S_FETCH) && (state != S_FETCH) && (state != S_DECODE);

    // Free-running cycle counter and retired-instruction counter, both wrapping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Cycle_Count_o   <= '0;
            Retired_Count_o <= '0;
        end else begin
            Cycle_Count_o <= Cycle_Count_o + NBits'(1);
            if (retire) begin
                Retired_Count_o <= Retired_Count_o + NBits'(1);
            end
        end
    end
`endif

endmodule
